// File: rtl/rotary_pkg.sv
// Shared codes, states and helpers for the rotary encoder front end.
package rotary_pkg;

  localparam logic [1:0] ROT_NONE  = 2'b00;
  localparam logic [1:0] ROT_LEFT  = 2'b01;
  localparam logic [1:0] ROT_RIGHT = 2'b10;

  // Detent rest value of the filtered {a,b} pair
  localparam logic [1:0] Q_REST = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    R1   = 3'd1,
    R2   = 3'd2,
    R3   = 3'd3,
    L1   = 3'd4,
    L2   = 3'd5,
    L3   = 3'd6,
    ERR  = 3'd7
  } quad_state_e;

  // Both bits flipping at once can never happen on a healthy quadrature encoder
  function automatic logic isDoubleStep(input logic [1:0] qNow, input logic [1:0] qPrev);
    return (qNow ^ qPrev) == 2'b11;
  endfunction

endpackage

// File: rtl/rotary_quadrature_filter_debounce_bit.sv
// Two-flop synchroniser followed by a stable-count debouncer for one encoder pin.
module debounce_bit
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic filtered_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filtered_q;
  logic [CW-1:0] count_q;

  // Bring the asynchronous pin into the clock domain; pins idle high
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed from the filtered value for the full window
  always_ff @(posedge clock) begin
    if (reset) begin
      filtered_q <= 1'b1;
      count_q    <= '0;
    end else if (sync2_q == filtered_q) begin
      count_q <= '0;
    end else if (count_q == COUNT_LAST) begin
      filtered_q <= sync2_q;
      count_q    <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign filtered_o = filtered_q;

endmodule

// File: rtl/rotary_quadrature_filter.sv
// Rotary encoder front end: debounced A/B pins decoded into one step code per full detent.
module rotary_quadrature_filter
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_CYCLES    = 1,
  parameter int SWAP_AB         = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rotary_a,
  input  logic       rotary_b,
  output logic [1:0] rotary,
  output logic       seq_error
);

  localparam int HW = $clog2(PULSE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(PULSE_CYCLES - 1);

  logic          filtA;
  logic          filtB;
  logic [1:0]    q;
  quad_state_e   state_q;
  quad_state_e   state_d;
  logic [1:0]    qPrev_q;
  logic [1:0]    emitCode;
  logic          stepError;
  logic [1:0]    rotary_q;
  logic [HW-1:0] holdCnt_q;
  logic          gap_q;
  logic          seqError_q;

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) debounceA (
    .clock     (clock),
    .reset     (reset),
    .pin_i     (rotary_a),
    .filtered_o(filtA)
  );

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) debounceB (
    .clock     (clock),
    .reset     (reset),
    .pin_i     (rotary_b),
    .filtered_o(filtB)
  );

  // Both pin paths are identical, so swapping after the filters equals swapping after the synchronisers
  assign q = (SWAP_AB != 0) ? {filtB, filtA} : {filtA, filtB};

  // Decoder state and the previous filtered pair used to spot double-bit jumps
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      qPrev_q <= Q_REST;
    end else begin
      state_q <= state_d;
      qPrev_q <= q;
    end
  end

  // Walk the quadrature cycle; a step is only emitted when a full cycle lands back on the detent
  always_comb begin
    state_d   = state_q;
    emitCode  = ROT_NONE;
    stepError = 1'b0;
    if (isDoubleStep(q, qPrev_q)) begin
      state_d   = ERR;
      stepError = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (q == 2'b10) state_d = R1; else if (q == 2'b01) state_d = L1;
        R1:   if (q == 2'b00) state_d = R2; else if (q == Q_REST) state_d = IDLE;
        R2:   if (q == 2'b01) state_d = R3; else if (q == 2'b10) state_d = R1;
        R3: begin
          if (q == Q_REST) begin
            state_d  = IDLE;
            emitCode = ROT_RIGHT;
          end else if (q == 2'b00) begin
            state_d = R2;
          end
        end
        L1:   if (q == 2'b00) state_d = L2; else if (q == Q_REST) state_d = IDLE;
        L2:   if (q == 2'b10) state_d = L3; else if (q == 2'b01) state_d = L1;
        L3: begin
          if (q == Q_REST) begin
            state_d  = IDLE;
            emitCode = ROT_LEFT;
          end else if (q == 2'b00) begin
            state_d = L2;
          end
        end
        ERR:  if (q == Q_REST) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Hold each step code for the pulse length, then force a rearm gap so 01 and 10 never touch
  always_ff @(posedge clock) begin
    if (reset) begin
      rotary_q   <= ROT_NONE;
      holdCnt_q  <= '0;
      gap_q      <= 1'b0;
      seqError_q <= 1'b0;
    end else begin
      seqError_q <= stepError;
      if (rotary_q != ROT_NONE) begin
        if (holdCnt_q == HOLD_LAST) begin
          rotary_q  <= ROT_NONE;
          gap_q     <= 1'b1;
          holdCnt_q <= '0;
        end else begin
          holdCnt_q <= holdCnt_q + 1'b1;
        end
      end else if (gap_q) begin
        gap_q <= 1'b0;
      end else if (emitCode != ROT_NONE) begin
        rotary_q  <= emitCode;
        holdCnt_q <= '0;
      end
    end
  end

  assign rotary    = rotary_q;
  assign seq_error = seqError_q;

endmodule

// File: tb/tb_rotary_quadrature_filter.sv
// Scoreboard bench: two filter instances (plain, and 3-cycle pulse with A/B swapped) share the pins.
module tb_rotary_quadrature_filter;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rotaryA = 1'b1;
  logic       rotaryB = 1'b1;
  logic [1:0] rot0;
  logic [1:0] rot1;
  logic       err0;
  logic       err1;

  int cycleCount = 0;
  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    int         dut;
    bit         isErr;
    logic [1:0] code;
    int         cycle;
    int         len;
  } exp_t;

  exp_t expQ[$];

  int         pulseLen[2] = '{1, 3};
  int         disp[2];
  bit         errMode[2];
  logic [1:0] prevQ[2];
  logic [1:0] posQ[4] = '{2'b11, 2'b10, 2'b00, 2'b01};

  bit         runActive[2];
  logic [1:0] runCode[2];
  int         runLen[2];
  int         runStart[2];

  always #5 clock = ~clock;

  // Count posedges so expected arrival times can be stated in cycles
  always @(posedge clock) cycleCount <= cycleCount + 1;

  rotary_quadrature_filter #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(1), .SWAP_AB(0)) dut0 (
    .clock    (clock),
    .reset    (reset),
    .rotary_a (rotaryA),
    .rotary_b (rotaryB),
    .rotary   (rot0),
    .seq_error(err0)
  );

  rotary_quadrature_filter #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(3), .SWAP_AB(1)) dut1 (
    .clock    (clock),
    .reset    (reset),
    .rotary_a (rotaryA),
    .rotary_b (rotaryB),
    .rotary   (rot1),
    .seq_error(err1)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  function automatic int gpos(input logic [1:0] q);
    case (q)
      2'b11:   return 0;
      2'b10:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic void pushExp(input int d, input bit isErr, input logic [1:0] code, input int cyc, input int len);
    exp_t e;
    e.dut = d;
    e.isErr = isErr;
    e.code = code;
    e.cycle = cyc;
    e.len = len;
    expQ.push_back(e);
  endfunction

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      disp[d] = 0;
      errMode[d] = 1'b0;
      prevQ[d] = 2'b11;
    end
  endfunction

  // Reference: track signed travel around the gray cycle; +4/-4 back at rest is one detent
  function automatic void modelEdge(input logic [1:0] pins, input int cyc);
    for (int d = 0; d < 2; d++) begin
      logic [1:0] qm;
      int delta;
      qm = (d == 1) ? {pins[0], pins[1]} : pins;
      if (qm != prevQ[d]) begin
        if ((qm ^ prevQ[d]) == 2'b11) begin
          pushExp(d, 1'b1, 2'b00, cyc + LAT, 1);
          errMode[d] = 1'b1;
          disp[d] = 0;
        end else if (!errMode[d]) begin
          delta = (gpos(qm) - gpos(prevQ[d]) + 4) % 4;
          disp[d] += (delta == 1) ? 1 : -1;
        end
        if (qm == 2'b11) begin
          if (!errMode[d] && disp[d] == 4)  pushExp(d, 1'b0, 2'b10, cyc + LAT, pulseLen[d]);
          if (!errMode[d] && disp[d] == -4) pushExp(d, 1'b0, 2'b01, cyc + LAT, pulseLen[d]);
          errMode[d] = 1'b0;
          disp[d] = 0;
        end
        prevQ[d] = qm;
      end
    end
  endfunction

  task automatic matchPop(input int d, input bit isErr, input logic [1:0] code, input int cyc, input int len);
    int idx;
    idx = -1;
    for (int i = 0; i < expQ.size(); i++) begin
      if (idx < 0 && expQ[i].dut == d && expQ[i].isErr == isErr) idx = i;
    end
    if (idx < 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL unexpected dut%0d %s: code %b at cycle %0d, none expected",
               d, isErr ? "seq_error" : "step", code, cyc);
    end else begin
      checkOutput($sformatf("dut%0d.%s.cycle", d, isErr ? "err" : "step"), cyc, expQ[idx].cycle);
      if (!isErr) begin
        checkOutput($sformatf("dut%0d.step.code", d), int'(code), int'(expQ[idx].code));
        checkOutput($sformatf("dut%0d.step.len", d), len, expQ[idx].len);
      end
      expQ.delete(idx);
    end
  endtask

  // Monitor: collect each nonzero rotary run and each seq_error pulse and score it
  always @(negedge clock) begin
    if (reset) begin
      runActive[0] = 1'b0;
      runActive[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [1:0] r;
        logic e;
        r = (d == 0) ? rot0 : rot1;
        e = (d == 0) ? err0 : err1;
        if (runActive[d]) begin
          if (r == runCode[d]) begin
            runLen[d]++;
          end else begin
            matchPop(d, 1'b0, runCode[d], runStart[d], runLen[d]);
            runActive[d] = 1'b0;
          end
        end
        if (!runActive[d] && r != 2'b00) begin
          runActive[d] = 1'b1;
          runCode[d] = r;
          runLen[d] = 1;
          runStart[d] = cycleCount;
        end
        if (e) matchPop(d, 1'b1, 2'b00, cycleCount, 1);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Move the pins to q, optionally bouncing first, then hold
  task automatic applyStimulus(input logic [1:0] q, input int hold, input bit bounce);
    logic [1:0] old;
    old = {rotaryA, rotaryB};
    if (q != old) begin
      if (bounce) begin
        {rotaryA, rotaryB} = q;
        waitCycles($urandom_range(1, DEB - 1));
        {rotaryA, rotaryB} = old;
        waitCycles($urandom_range(1, DEB - 1));
      end
      {rotaryA, rotaryB} = q;
      modelEdge(q, cycleCount);
    end
    waitCycles(hold);
  endtask

  task automatic detent(input bit right, input bit bounce);
    if (right) begin
      applyStimulus(2'b10, 10, bounce);
      applyStimulus(2'b00, 10, bounce);
      applyStimulus(2'b01, 10, bounce);
    end else begin
      applyStimulus(2'b01, 10, bounce);
      applyStimulus(2'b00, 10, bounce);
      applyStimulus(2'b10, 10, bounce);
    end
    applyStimulus(2'b11, 10, bounce);
  endtask

  initial begin
    logic [1:0] q;
    int pos;
    int dir;
    modelReset();
    reset = 1'b1;
    waitCycles(1);
    for (int i = 0; i < 3; i++) begin
      {rotaryA, rotaryB} = 2'($urandom);
      @(negedge clock);
      checkOutput("reset.rot0", int'(rot0), 0);
      checkOutput("reset.rot1", int'(rot1), 0);
      checkOutput("reset.err0", int'(err0), 0);
      checkOutput("reset.err1", int'(err1), 0);
      @(posedge clock);
      #1;
    end
    {rotaryA, rotaryB} = 2'b11;
    waitCycles(1);
    reset = 1'b0;
    waitCycles(20);

    detent(1'b1, 1'b0);
    detent(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) detent(1'b0, 1'b0);
    detent(1'b1, 1'b1);

    applyStimulus(2'b10, 10, 1'b0);
    applyStimulus(2'b00, 10, 1'b0);
    applyStimulus(2'b10, 10, 1'b0);
    applyStimulus(2'b11, 10, 1'b0);
    detent(1'b0, 1'b0);

    applyStimulus(2'b00, 10, 1'b0);
    applyStimulus(2'b01, 10, 1'b0);
    applyStimulus(2'b11, 10, 1'b0);
    detent(1'b1, 1'b0);

    applyStimulus(2'b10, 10, 1'b0);
    applyStimulus(2'b00, 10, 1'b0);
    applyStimulus(2'b01, 10, 1'b0);
    reset = 1'b1;
    {rotaryA, rotaryB} = 2'b11;
    waitCycles(2);
    reset = 1'b0;
    modelReset();
    waitCycles(12);
    detent(1'b0, 1'b0);

    pos = 0;
    dir = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        q = {rotaryA, rotaryB} ^ 2'b11;
      end else begin
        if ($urandom_range(0, 4) == 0) dir = -dir;
        pos = (pos + dir + 4) % 4;
        q = posQ[pos];
      end
      pos = gpos(q);
      applyStimulus(q, $urandom_range(6, 12), $urandom_range(0, 3) == 0);
    end
    applyStimulus(2'b11, 12, 1'b0);
    waitCycles(30);

    foreach (expQ[i]) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL missing dut%0d %s: never seen, expected at cycle %0d",
               expQ[i].dut, expQ[i].isErr ? "seq_error" : "step", expQ[i].cycle);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
